id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
//
// PURPOSE
// - ID/EX pipeline register feeding the ALU: captures decoded instruction fields and register-file
//   operands, applies EX/MEM and MEM/WB forwarding, and presents SrcA/SrcB/Operation to the ALU.
// - Sits between the decoder/register-file read and the combinational ALU.
// - Single-entry buffer with a valid/ready handshake on both sides, plus a flush input for
//   branch/jal redirect.
//
// PARAMETERS
// - DATA_WIDTH      32  operand/result width
// - OPCODE_LENGTH    4  ALU Operation code width (ALU encoding, passed through unmodified)
// - REG_ADDR_WIDTH   5  register index width
//
// PORTS
// - clk            in   1        sole clock, rising edge
// - reset          in   1        synchronous, active-high
// - in_valid       in   1        decode presents an instruction
// - in_ready       out  1        stage can accept (= !out_valid | out_ready)
// - in_rs1_addr    in   RAW      source 1 index
// - in_rs2_addr    in   RAW      source 2 index
// - in_rs1_data    in   DW       register-file read 1
// - in_rs2_data    in   DW       register-file read 2
// - in_imm         in   DW       sign-extended immediate
// - in_pc          in   DW       instruction PC
// - in_use_imm     in   1        SrcB = imm instead of rs2
// - in_use_pc      in   1        SrcA = pc instead of rs1
// - in_operation   in   OPL      ALU Operation code
// - in_rd_addr     in   RAW      destination index
// - in_reg_write   in   1        instruction writes rd
// - flush          in   1        kill held and incoming instruction
// - fwd_mem_valid  in   1        EX/MEM result writes a register
// - fwd_mem_rd     in   RAW      EX/MEM destination
// - fwd_mem_data   in   DW       EX/MEM result
// - fwd_wb_valid   in   1        MEM/WB result writes a register
// - fwd_wb_rd      in   RAW      MEM/WB destination
// - fwd_wb_data    in   DW       MEM/WB result
// - out_valid      out  1        ALU operands valid
// - out_ready      in   1        downstream consumes this cycle
// - SrcA           out  DW       ALU operand A
// - SrcB           out  DW       ALU operand B
// - Operation      out  OPL      ALU operation
// - out_rs2_data   out  DW       forwarded rs2 (store data)
// - out_rd_addr    out  RAW      destination index
// - out_reg_write  out  1        write-enable
// - out_pc         out  DW       registered PC
//
// BEHAVIOUR
// Reset and handshake
// - Reset: out_valid=0; all registered fields=0, so SrcA/SrcB/Operation/out_* read 0.
//   Reset mid-transfer drops the held instruction.
// - Load when in_valid & in_ready, visible the next cycle (1-cycle latency).
// - out_valid next = flush ? 0 : (load ? 1 : (out_ready ? 0 : out_valid)).
// - flush dominates: a same-cycle load is discarded, and in_ready is unaffected by flush.
// - While out_valid & !out_ready, all fields hold.
//
// Operand capture and forwarding
// - Load-time capture: stored rs data = (fwd_wb_valid & fwd_wb_rd==in_rsN_addr & addr!=0)
//   ? fwd_wb_data : in_rsN_data. This covers write-then-read in the same cycle.
// - Combinational forward per source on the stored address: MEM match > WB match > stored data.
//   A match requires valid & rd==addr & addr!=0.
// - Index 0 always yields 0, regardless of the data presented.
// - Hold refresh: each cycle with out_valid & !out_ready, a stored operand that has a forward
//   match is overwritten with the forwarded value, so the value survives the producer retiring.
// - SrcA = use_pc ? out_pc : fwdA.
// - SrcB = use_imm ? imm : fwdB.
// - out_rs2_data = fwdB (always, independent of use_imm).
// - Arithmetic: none; widths pass through unmodified.
//
// CONFIGURATION
// - ID_EX_FORWARD_EN defined: forwarding, load-time capture and hold refresh are enabled as above.
// - ID_EX_FORWARD_EN undefined:
//   - stored data = in_rsN_data; fwdA/fwdB = stored data (x0 still forced to 0);
//   - fwd_* inputs are ignored;
//   - the hazard unit must stall instead.
//
// TESTING
// 1. Reset held 2 cycles with in_valid=1 -> out_valid=0, SrcA=SrcB=0, in_ready=1.
// 2. Load rs1=5, data=0x10, Operation=4'b0010; fwd_mem_valid, fwd_mem_rd=5, data=0x99
//    -> next cycle SrcA=0x99.
// 3. MEM and WB both target rs2=7 (MEM 0xA, WB 0xB) -> SrcB=0xA; with in_use_imm=1, imm=0x4
//    -> SrcB=0x4, out_rs2_data=0xA.
// 4. out_ready=0 for 3 cycles, WB forwards rs1=3=0x55 in cycle 1 only
//    -> SrcA=0x55 in cycles 1-3, in_ready=0, fields stable.
// 5. flush with in_valid=1 & in_ready=1 -> next cycle out_valid=0.
//    rs1=0 with fwd_mem_rd=0 -> SrcA=0.
// 6. Back-to-back loads with out_ready=1 -> one instruction per cycle, no bubbles, ordering kept.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register in front of the ALU.
// Single-entry valid/ready buffer that captures decoded fields and register
// operands, resolves EX/MEM and MEM/WB forwarding, and drives SrcA/SrcB/Operation.
// Optional feature macro: ID_EX_FORWARD_EN enables load-time WB capture,
// combinational forwarding and hold refresh. When it is undefined, the stored
// register-file data is used unchanged and the hazard unit must stall.
module id_ex_operand_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned OPCODE_LENGTH  = 4,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  // decode side
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr,
  input  logic [DATA_WIDTH-1:0]     in_rs1_data,
  input  logic [DATA_WIDTH-1:0]     in_rs2_data,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  input  logic [DATA_WIDTH-1:0]     in_pc,
  input  logic                      in_use_imm,
  input  logic                      in_use_pc,
  input  logic [OPCODE_LENGTH-1:0]  in_operation,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
  input  logic                      in_reg_write,
  // redirect
  input  logic                      flush,
  // forwarding sources
  input  logic                      fwd_mem_valid,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_mem_rd,
  input  logic [DATA_WIDTH-1:0]     fwd_mem_data,
  input  logic                      fwd_wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_wb_rd,
  input  logic [DATA_WIDTH-1:0]     fwd_wb_data,
  // ALU side
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic [DATA_WIDTH-1:0]     out_rs2_data,
  output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
  output logic                      out_reg_write,
  output logic [DATA_WIDTH-1:0]     out_pc
);

  // handshake
  logic                      valid_q;
  logic                      take;
  logic                      capture;
  logic                      hold;

  // stored instruction
  logic [REG_ADDR_WIDTH-1:0] rs1_addr_q;
  logic [REG_ADDR_WIDTH-1:0] rs2_addr_q;
  logic [DATA_WIDTH-1:0]     rs1_data_q;
  logic [DATA_WIDTH-1:0]     rs2_data_q;
  logic [DATA_WIDTH-1:0]     imm_q;
  logic [DATA_WIDTH-1:0]     pc_q;
  logic                      use_imm_q;
  logic                      use_pc_q;
  logic [OPCODE_LENGTH-1:0]  operation_q;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
  logic                      reg_write_q;

  // forwarding results
  logic                      mem_hit_a;
  logic                      mem_hit_b;
  logic                      wb_hit_a;
  logic                      wb_hit_b;
  logic [DATA_WIDTH-1:0]     cap_rs1;
  logic [DATA_WIDTH-1:0]     cap_rs2;
  logic [DATA_WIDTH-1:0]     fwd_a;
  logic [DATA_WIDTH-1:0]     fwd_b;

  // Flush does not back-pressure decode; it only discards what is accepted.
  assign in_ready = !valid_q || out_ready;
  assign take     = in_valid && in_ready;
  assign capture  = take && !flush;
  assign hold     = valid_q && !out_ready;

  // Occupancy: flush beats load, load beats drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (take) begin
      valid_q <= 1'b1;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Control fields and immediates: captured on accept, otherwise held.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      use_imm_q   <= 1'b0;
      use_pc_q    <= 1'b0;
      operation_q <= '0;
      rd_addr_q   <= '0;
      reg_write_q <= 1'b0;
    end else if (capture) begin
      rs1_addr_q  <= in_rs1_addr;
      rs2_addr_q  <= in_rs2_addr;
      imm_q       <= in_imm;
      pc_q        <= in_pc;
      use_imm_q   <= in_use_imm;
      use_pc_q    <= in_use_pc;
      operation_q <= in_operation;
      rd_addr_q   <= in_rd_addr;
      reg_write_q <= in_reg_write;
    end
  end

  // Operand data: capture on accept; while stalled, latch any forwarded value
  // so it survives the producing instruction leaving the pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else if (capture) begin
      rs1_data_q <= cap_rs1;
      rs2_data_q <= cap_rs2;
    end else if (hold) begin
      if (mem_hit_a || wb_hit_a) begin
        rs1_data_q <= fwd_a;
      end
      if (mem_hit_b || wb_hit_b) begin
        rs2_data_q <= fwd_b;
      end
    end
  end

`ifdef ID_EX_FORWARD_EN
  // Match detection on stored addresses and WB write-through at capture time.
  always_comb begin
    mem_hit_a = fwd_mem_valid && (fwd_mem_rd == rs1_addr_q) && (rs1_addr_q != '0);
    mem_hit_b = fwd_mem_valid && (fwd_mem_rd == rs2_addr_q) && (rs2_addr_q != '0);
    wb_hit_a  = fwd_wb_valid  && (fwd_wb_rd  == rs1_addr_q) && (rs1_addr_q != '0);
    wb_hit_b  = fwd_wb_valid  && (fwd_wb_rd  == rs2_addr_q) && (rs2_addr_q != '0);
    cap_rs1   = in_rs1_data;
    cap_rs2   = in_rs2_data;
    if (fwd_wb_valid && (fwd_wb_rd == in_rs1_addr) && (in_rs1_addr != '0)) begin
      cap_rs1 = fwd_wb_data;
    end
    if (fwd_wb_valid && (fwd_wb_rd == in_rs2_addr) && (in_rs2_addr != '0)) begin
      cap_rs2 = fwd_wb_data;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                        fwd_wb_valid, fwd_wb_rd, fwd_wb_data};

  // No bypass network: register-file data is used as read.
  always_comb begin
    mem_hit_a = 1'b0;
    mem_hit_b = 1'b0;
    wb_hit_a  = 1'b0;
    wb_hit_b  = 1'b0;
    cap_rs1   = in_rs1_data;
    cap_rs2   = in_rs2_data;
  end
`endif

  // Operand select: MEM beats WB beats stored data; x0 always reads zero.
  always_comb begin
    fwd_a = rs1_data_q;
    fwd_b = rs2_data_q;
`ifdef ID_EX_FORWARD_EN
    if (wb_hit_a) begin
      fwd_a = fwd_wb_data;
    end
    if (mem_hit_a) begin
      fwd_a = fwd_mem_data;
    end
    if (wb_hit_b) begin
      fwd_b = fwd_wb_data;
    end
    if (mem_hit_b) begin
      fwd_b = fwd_mem_data;
    end
`endif
    if (rs1_addr_q == '0) begin
      fwd_a = '0;
    end
    if (rs2_addr_q == '0) begin
      fwd_b = '0;
    end
  end

  // ALU-facing outputs.
  assign out_valid     = valid_q;
  assign SrcA          = use_pc_q  ? pc_q  : fwd_a;
  assign SrcB          = use_imm_q ? imm_q : fwd_b;
  assign Operation     = operation_q;
  assign out_rs2_data  = fwd_b;
  assign out_rd_addr   = rd_addr_q;
  assign out_reg_write = reg_write_q;
  assign out_pc        = pc_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage; expectations follow ID_EX_FORWARD_EN.
module tb_id_ex_operand_stage;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic        in_use_imm, in_use_pc, in_reg_write;
  logic [3:0]  in_operation;
  logic        flush;
  logic        fwd_mem_valid, fwd_wb_valid;
  logic [4:0]  fwd_mem_rd, fwd_wb_rd;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        out_valid, out_ready;
  logic [31:0] SrcA, SrcB, out_rs2_data, out_pc;
  logic [3:0]  Operation;
  logic [4:0]  out_rd_addr;
  logic        out_reg_write;

  int errors = 0;
  int checks = 0;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_pc(in_pc),
    .in_use_imm(in_use_imm), .in_use_pc(in_use_pc),
    .in_operation(in_operation), .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
    .flush(flush),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .out_rs2_data(out_rs2_data), .out_rd_addr(out_rd_addr),
    .out_reg_write(out_reg_write), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0; in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0;
    in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_pc = '0;
    in_use_imm = 1'b0; in_use_pc = 1'b0; in_reg_write = 1'b0; in_operation = '0;
    flush = 1'b0; out_ready = 1'b1;
    fwd_mem_valid = 1'b0; fwd_mem_rd = '0; fwd_mem_data = '0;
    fwd_wb_valid = 1'b0; fwd_wb_rd = '0; fwd_wb_data = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    in_valid = 1'b1; in_rs1_addr = 5'd3; in_rs1_data = 32'h1234; in_pc = 32'h40;
    in_operation = 4'b1010;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    checks++; if (SrcA !== 32'h0) begin errors++; $display("FAIL reset SrcA got %h want 0", SrcA); end
    checks++; if (SrcB !== 32'h0) begin errors++; $display("FAIL reset SrcB got %h want 0", SrcB); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    checks++; if (Operation !== 4'h0) begin errors++; $display("FAIL reset Operation got %h want 0", Operation); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset out_pc got %h want 0", out_pc); end
    reset = 1'b0;
    clear_inputs();
  endtask

  task automatic test_mem_forward();
    logic [31:0] exp_a;
    clear_inputs();
    in_valid = 1'b1; in_rs1_addr = 5'd5; in_rs1_data = 32'h10; in_operation = 4'b0010;
    in_rd_addr = 5'd1; in_reg_write = 1'b1; in_pc = 32'h100;
    fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd5; fwd_mem_data = 32'h99;
    tick();
    in_valid = 1'b0;
    exp_a = FWD ? 32'h99 : 32'h10;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL memfwd out_valid got %b want 1", out_valid); end
    checks++; if (SrcA !== exp_a) begin errors++; $display("FAIL memfwd SrcA got %h want %h", SrcA, exp_a); end
    checks++; if (Operation !== 4'b0010) begin errors++; $display("FAIL memfwd Operation got %h want 2", Operation); end
    checks++; if (out_rd_addr !== 5'd1 || out_reg_write !== 1'b1) begin
      errors++; $display("FAIL memfwd rd got %0d/%b want 1/1", out_rd_addr, out_reg_write); end
    checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL memfwd out_pc got %h want 100", out_pc); end
    tick();
    clear_inputs();
  endtask

  task automatic test_priority();
    logic [31:0] exp_b;
    clear_inputs();
    in_valid = 1'b1; in_rs2_addr = 5'd7; in_rs2_data = 32'h3;
    fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd7; fwd_mem_data = 32'hA;
    fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd7; fwd_wb_data = 32'hB;
    tick();
    exp_b = FWD ? 32'hA : 32'h3;
    checks++; if (SrcB !== exp_b) begin errors++; $display("FAIL prio SrcB got %h want %h", SrcB, exp_b); end
    // next instruction uses the immediate, same forwarding in flight
    in_use_imm = 1'b1; in_imm = 32'h4;
    tick();
    in_valid = 1'b0;
    checks++; if (SrcB !== 32'h4) begin errors++; $display("FAIL prio_imm SrcB got %h want 4", SrcB); end
    checks++; if (out_rs2_data !== exp_b) begin errors++; $display("FAIL prio_imm rs2_data got %h want %h", out_rs2_data, exp_b); end
    // producers retire: WB value captured at load must remain
    fwd_mem_valid = 1'b0; fwd_wb_valid = 1'b0;
    #1;
    exp_b = FWD ? 32'hB : 32'h3;
    checks++; if (out_rs2_data !== exp_b) begin errors++; $display("FAIL wb_capture rs2_data got %h want %h", out_rs2_data, exp_b); end
    tick();
    clear_inputs();
  endtask

  task automatic test_hold_refresh();
    logic [31:0] exp_a;
    clear_inputs();
    in_valid = 1'b1; in_rs1_addr = 5'd3; in_rs1_data = 32'h30; in_operation = 4'b0111;
    in_pc = 32'h200; out_ready = 1'b0;
    tick();
    // a competing instruction must not be accepted while stalled
    in_rs1_addr = 5'd4; in_rs1_data = 32'hEE; in_pc = 32'h300; in_operation = 4'b0001;
    fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd3; fwd_wb_data = 32'h55;
    #1;
    exp_a = FWD ? 32'h55 : 32'h30;
    checks++; if (SrcA !== exp_a) begin errors++; $display("FAIL hold c1 SrcA got %h want %h", SrcA, exp_a); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold c1 in_ready got %b want 0", in_ready); end
    tick();
    fwd_wb_valid = 1'b0;
    #1;
    checks++; if (SrcA !== exp_a) begin errors++; $display("FAIL hold c2 SrcA got %h want %h", SrcA, exp_a); end
    checks++; if (out_pc !== 32'h200 || Operation !== 4'b0111) begin
      errors++; $display("FAIL hold c2 fields got %h/%h want 200/7", out_pc, Operation); end
    tick();
    checks++; if (SrcA !== exp_a) begin errors++; $display("FAIL hold c3 SrcA got %h want %h", SrcA, exp_a); end
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL hold c3 valid/ready got %b/%b want 1/0", out_valid, in_ready); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold drain out_valid got %b want 0", out_valid); end
    clear_inputs();
  endtask

  task automatic test_flush();
    clear_inputs();
    in_valid = 1'b1; flush = 1'b1; in_rs1_addr = 5'd1; in_rs1_data = 32'h5;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush in_ready got %b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_load out_valid got %b want 0", out_valid); end
    // flush of a held instruction
    flush = 1'b0; in_pc = 32'h400; out_ready = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_held pre out_valid got %b want 1", out_valid); end
    in_valid = 1'b0; flush = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_held out_valid got %b want 0", out_valid); end
    // x0 ignores forwarding and register-file data
    clear_inputs();
    in_valid = 1'b1; in_rs1_data = 32'hDEAD; in_rs2_data = 32'hBEEF;
    fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd0; fwd_mem_data = 32'h99;
    fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd0; fwd_wb_data = 32'h77;
    tick();
    in_valid = 1'b0;
    checks++; if (SrcA !== 32'h0) begin errors++; $display("FAIL x0 SrcA got %h want 0", SrcA); end
    checks++; if (out_rs2_data !== 32'h0) begin errors++; $display("FAIL x0 rs2_data got %h want 0", out_rs2_data); end
    tick();
    // reset drops a held instruction and clears fields
    clear_inputs();
    in_valid = 1'b1; in_rs1_addr = 5'd2; in_rs1_data = 32'h22; in_pc = 32'h500; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset out_valid got %b want 0", out_valid); end
    checks++; if (out_pc !== 32'h0 || SrcA !== 32'h0) begin
      errors++; $display("FAIL midreset fields got %h/%h want 0/0", out_pc, SrcA); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_a;
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'h1000 + 32'(4 * i);
      in_rs1_addr = 5'(i + 1); in_rs1_data = 32'h100 + 32'(i);
      in_use_pc = (i == 2);
      tick();
      exp_a = (i == 2) ? 32'h1000 + 32'(4 * i) : 32'h100 + 32'(i);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b[%0d] valid/ready got %b/%b want 1/1", i, out_valid, in_ready); end
      checks++; if (out_pc !== 32'h1000 + 32'(4 * i)) begin
        errors++; $display("FAIL b2b[%0d] out_pc got %h want %h", i, out_pc, 32'h1000 + 32'(4 * i)); end
      checks++; if (SrcA !== exp_a) begin errors++; $display("FAIL b2b[%0d] SrcA got %h want %h", i, SrcA, exp_a); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b drain out_valid got %b want 0", out_valid); end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_mem_forward();
    test_priority();
    test_hold_refresh();
    test_flush();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
